spike_packetizer: RTL and testbench

Converts the per-tick neuron spike vector of a core into a serial stream of outbound spike packets. Each packet carries a destination core offset, an axon index, and a delivery tick delay, so that a receiving core's scheduler can store it at the correct future tick slot. The block sits between the neuron block and the router's local input port. It reads each firing neuron's destination from an external destination table.

---
 rtl/spike_packetizer.sv | 106 ++++++++++
 tb/tb_spike_packetizer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_packetizer.sv
// spike_packetizer: turns the per-tick spike vector of a core into a serial
// stream of outbound spike packets, one per firing neuron in ascending index
// order. Each neuron's destination comes from an external table that is
// addressed by dest_addr and answers on dest_data one cycle later.
module spike_packetizer #(
    parameter int NUM_NEURONS = 256,
    parameter int NUM_AXONS   = 256,
    parameter int NUM_TICKS   = 16,
    parameter int DX_WIDTH    = 9,
    parameter int DY_WIDTH    = 9,
    localparam int AW           = $clog2(NUM_NEURONS),
    localparam int PACKET_WIDTH = DX_WIDTH + DY_WIDTH + $clog2(NUM_AXONS) + $clog2(NUM_TICKS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [NUM_NEURONS-1:0]  spikes_in,
    output logic [AW-1:0]           dest_addr,
    input  logic [PACKET_WIDTH-1:0] dest_data,
    output logic [PACKET_WIDTH-1:0] packet_out,
    output logic                    packet_valid,
    input  logic                    packet_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, SEND} state_t;

    state_t                  r_state;
    logic [NUM_NEURONS-1:0]  r_pending;
    logic [AW-1:0]           r_dest_addr;
    logic [PACKET_WIDTH-1:0] r_packet;
    logic                    r_valid;
    logic                    r_done;
    logic                    r_error;

    logic [AW-1:0]           w_idx;
    logic                    w_any;

    // Priority encoder: lowest set bit of the pending vector, resolved within the SCAN cycle
    always_comb begin
        w_idx = '0;
        w_any = |r_pending;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (r_pending[i]) w_idx = AW'(i);
        end
    end

    // Control FSM; all outputs except busy are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_dest_addr <= '0;
            r_packet    <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            // A tick outside IDLE is dropped; flag it the following cycle
            r_error <= tick && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (tick) begin
                        r_pending <= spikes_in;
                        r_state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (!w_any) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_dest_addr      <= w_idx;
                        r_pending[w_idx] <= 1'b0;
                        r_state          <= FETCH;
                    end
                end
                FETCH: begin
                    // Table answers in this cycle for the address set in SCAN
                    r_packet <= dest_data;
                    r_valid  <= 1'b1;
                    r_state  <= SEND;
                end
                SEND: begin
                    // packet_out is held untouched until the router accepts it
                    if (packet_ready) begin
                        r_valid <= 1'b0;
                        r_state <= SCAN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dest_addr    = r_dest_addr;
    assign packet_out   = r_packet;
    assign packet_valid = r_valid;
    assign done         = r_done;
    assign error        = r_error;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_spike_packetizer.sv
// Directed bench for spike_packetizer. The destination table is modelled as
// a combinational array indexed by dest_addr. Inputs change and outputs are
// sampled 1ns after the rising edge, so after k steps from the tick cycle T
// the sampled values belong to cycle T+k.
module tb_spike_packetizer;

    localparam int NN = 256;
    localparam int PW = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [NN-1:0] spikes_in;
    logic [7:0]    dest_addr;
    logic [PW-1:0] dest_data;
    logic [PW-1:0] packet_out;
    logic          packet_valid;
    logic          packet_ready;
    logic          busy;
    logic          done;
    logic          error;

    logic [PW-1:0] tbl [NN];

    int n_cmp = 0;
    int n_bad = 0;

    spike_packetizer dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .spikes_in    (spikes_in),
        .dest_addr    (dest_addr),
        .dest_data    (dest_data),
        .packet_out   (packet_out),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    assign dest_data = tbl[dest_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a tick with the given vector for one cycle (current cycle = T)
    task automatic fire(input logic [NN-1:0] v);
        spikes_in = v;
        tick      = 1'b1;
        step();
        tick      = 1'b0;
        spikes_in = '0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".busy"},  busy, 1'b0);
        chk({tag, ".valid"}, packet_valid, 1'b0);
        chk({tag, ".addr"},  dest_addr, 8'd0);
        chk({tag, ".pkt"},   packet_out, 30'd0);
        chk({tag, ".done"},  done, 1'b0);
        chk({tag, ".err"},   error, 1'b0);
    endtask

    initial begin
        logic [PW-1:0] hold;
        int            nvalid;
        int            nerr;

        for (int i = 0; i < NN; i++)
            tbl[i] = {9'(i), 9'(-i), 8'(i ^ 8'hA5), 4'(i)};
        tbl[5] = {9'd1, 9'h1FF, 8'd17, 4'd3};

        rst = 1'b1; tick = 1'b0; spikes_in = '0; packet_ready = 1'b1;
        step(3);
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Single spike at neuron 5, ready high
        fire(NN'(1) << 5);                                   // now T+1
        chk("s1.busy_t1", busy, 1'b1);
        step();                                              // T+2
        chk("s1.addr_t2", dest_addr, 8'd5);
        chk("s1.valid_t2", packet_valid, 1'b0);
        step();                                              // T+3
        chk("s1.valid_t3", packet_valid, 1'b1);
        chk("s1.pkt_t3", packet_out, {9'd1, 9'h1FF, 8'd17, 4'd3});
        step();                                              // T+4
        chk("s1.valid_t4", packet_valid, 1'b0);
        chk("s1.done_t4", done, 1'b0);
        step();                                              // T+5
        chk("s1.done_t5", done, 1'b1);
        step();                                              // T+6
        chk("s1.done_t6", done, 1'b0);
        chk("s1.busy_t6", busy, 1'b0);

        // Multi-spike ordering: bits 200, 0, 63
        fire((NN'(1) << 200) | NN'(1) | (NN'(1) << 63));     // T+1
        step(2);                                             // T+3
        chk("m.valid_t3", packet_valid, 1'b1);
        chk("m.pkt0", packet_out, {9'd0, 9'd0, 8'hA5, 4'd0});
        step(3);                                             // T+6
        chk("m.valid_t6", packet_valid, 1'b1);
        chk("m.pkt63", packet_out, {9'd63, 9'h1C1, 8'h9A, 4'hF});
        step(3);                                             // T+9
        chk("m.valid_t9", packet_valid, 1'b1);
        chk("m.pkt200", packet_out, {9'd200, 9'h138, 8'h6D, 4'h8});
        step();                                              // T+10
        chk("m.done_t10", done, 1'b0);
        step();                                              // T+11
        chk("m.done_t11", done, 1'b1);
        step();

        // Backpressure: neuron 10, ready low for 4 valid cycles
        packet_ready = 1'b0;
        fire(NN'(1) << 10);                                  // T+1
        step(2);                                             // T+3
        chk("bp.valid_t3", packet_valid, 1'b1);
        chk("bp.pkt", packet_out, {9'd10, 9'h1F6, 8'hAF, 4'hA});
        hold = packet_out;
        for (int c = 0; c < 3; c++) begin
            step();                                          // T+4..T+6
            chk("bp.stall_valid", packet_valid, 1'b1);
            chk("bp.stall_pkt", packet_out, hold);
        end
        step();                                              // T+7: 5th valid cycle
        packet_ready = 1'b1;
        chk("bp.valid_t7", packet_valid, 1'b1);
        chk("bp.pkt_t7", packet_out, {9'd10, 9'h1F6, 8'hAF, 4'hA});
        step();                                              // T+8
        chk("bp.valid_t8", packet_valid, 1'b0);
        chk("bp.done_t8", done, 1'b0);
        step();                                              // T+9
        chk("bp.done_t9", done, 1'b1);
        step();

        // Empty tick
        fire('0);                                            // T+1
        chk("e.busy_t1", busy, 1'b1);
        chk("e.valid_t1", packet_valid, 1'b0);
        step();                                              // T+2
        chk("e.busy_t2", busy, 1'b0);
        chk("e.done_t2", done, 1'b1);
        chk("e.valid_t2", packet_valid, 1'b0);
        step();                                              // T+3
        chk("e.done_t3", done, 1'b0);
        step();

        // Tick while busy: second tick during the SEND stall
        packet_ready = 1'b0;
        fire(NN'(1) << 7);                                   // T+1
        step(3);                                             // T+4, stalled in SEND
        chk("tb.valid_t4", packet_valid, 1'b1);
        fire(NN'(1) << 3);                                   // T+5
        chk("tb.err_t5", error, 1'b1);
        step();                                              // T+6
        chk("tb.err_t6", error, 1'b0);
        chk("tb.pkt_t6", packet_out, {9'd7, 9'h1F9, 8'hA2, 4'h7});
        packet_ready = 1'b1;                                 // handshake in T+6
        step();                                              // T+7
        chk("tb.valid_t7", packet_valid, 1'b0);
        step();                                              // T+8
        chk("tb.done_t8", done, 1'b1);
        // Tick coincident with done is accepted
        fire(NN'(1) << 20);                                  // T'+1
        chk("cd.busy", busy, 1'b1);
        chk("cd.err", error, 1'b0);
        step();                                              // T'+2
        chk("cd.addr", dest_addr, 8'd20);
        step();                                              // T'+3
        chk("cd.valid", packet_valid, 1'b1);
        chk("cd.pkt", packet_out, {9'd20, 9'h1EC, 8'hB1, 4'h4});
        nvalid = 0; nerr = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (packet_valid) nvalid++;
            if (error) nerr++;
        end
        chk("cd.no_extra_pkts", 64'(nvalid), 64'd0);
        chk("cd.no_extra_err", 64'(nerr), 64'd0);
        chk("cd.idle", busy, 1'b0);

        // Mid-operation reset with 3 spikes outstanding
        packet_ready = 1'b0;
        fire((NN'(1) << 1) | (NN'(1) << 2) | (NN'(1) << 3)); // T+1
        step(2);                                             // T+3
        chk("r.valid_t3", packet_valid, 1'b1);
        step();                                              // T+4
        rst = 1'b1;
        step();                                              // T+5
        rst = 1'b0;
        packet_ready = 1'b1;
        chk_idle_outputs("r.after");
        step();
        chk("r.stay_idle", busy, 1'b0);
        fire(NN'(1) << 5);                                   // T+1
        step(2);                                             // T+3
        chk("r.valid_new", packet_valid, 1'b1);
        chk("r.pkt_new", packet_out, {9'd1, 9'h1FF, 8'd17, 4'd3});
        step();                                              // T+4
        chk("r.valid_t4", packet_valid, 1'b0);
        step();                                              // T+5
        chk("r.done_new", done, 1'b1);
        step();
        chk("r.idle_end", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
